// File: rtl/flght_cntrl_gen_pkg.sv
// -----------------------------------------------------------------------------
// flght_cntrl_pkg
// Shared constants, saturation helpers and the axis enumeration for the
// flght_cntrl_gen flight controller.
// No ports. Optional feature macro used by the design: FLGHT_I_TERM_EN.
// -----------------------------------------------------------------------------
package flght_cntrl_pkg;

    localparam int MIN_RUN_SPD = 416;
    localparam int CAL_SPEED   = 290;

    typedef enum logic [1:0] {
        AX_PTCH = 2'd0,
        AX_ROLL = 2'd1,
        AX_YAW  = 2'd2
    } axis_t;

    // Clamp a signed value into the range of a signed field of 'width' bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                       input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 32'sd1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

    // Clamp a signed value into [0, 2^width-1].
    function automatic logic [31:0] clamp_unsigned(input logic signed [31:0] value,
                                                    input int                 width);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< width) - 32'sd1;
        if (value < 32'sd0) begin
            return 32'd0;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/flght_cntrl_gen_if.sv
// -----------------------------------------------------------------------------
// flght_cntrl_gen_if
// Bundles the inertial/command inputs and the ESC speed outputs.
//   master : drives vld, inertial_cal, desired/measured angles, thrst;
//            receives the four motor speeds and out_vld.
//   slave  : the controller side (mirror of master).
// -----------------------------------------------------------------------------
interface flght_cntrl_gen_if #(
    parameter int THRST_W = 9,
    parameter int SPD_W   = 11
);
    logic                      vld;
    logic                      inertial_cal;
    logic signed [15:0]        d_ptch;
    logic signed [15:0]        d_roll;
    logic signed [15:0]        d_yaw;
    logic signed [15:0]        ptch;
    logic signed [15:0]        roll;
    logic signed [15:0]        yaw;
    logic        [THRST_W-1:0] thrst;
    logic        [SPD_W-1:0]   frnt_spd;
    logic        [SPD_W-1:0]   bck_spd;
    logic        [SPD_W-1:0]   lft_spd;
    logic        [SPD_W-1:0]   rght_spd;
    logic                      out_vld;

    modport master (
        output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, out_vld
    );

    modport slave (
        input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        output frnt_spd, bck_spd, lft_spd, rght_spd, out_vld
    );
endinterface

// File: rtl/flght_cntrl_gen_pd_axis.sv
// -----------------------------------------------------------------------------
// pd_axis
// One control axis: saturated error, circular previous-error queue for the
// D term with warm-up gating, P/D (optionally I) terms, registered pid.
// Ports: clk, rst (sync active-high), vld (sample strobe), cal (calibration),
//        act/des (16-bit signed measured/desired angle), pid_q (registered pid).
// Macro FLGHT_I_TERM_EN adds a saturating integral accumulator.
// -----------------------------------------------------------------------------
module pd_axis
    import flght_cntrl_pkg::*;
#(
    parameter int ERR_W         = 10,
    parameter int D_QUEUE_DEPTH = 12,
    parameter int D_DIFF_W      = 7,
    parameter int P_COEFF       = 6,
    parameter int D_COEFF       = 2,
    parameter int PID_W         = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic                    cal,
    input  logic signed [15:0]      act,
    input  logic signed [15:0]      des,
    output logic signed [PID_W-1:0] pid_q
);
    localparam int PTR_W = $clog2(D_QUEUE_DEPTH);
    localparam int CNT_W = $clog2(D_QUEUE_DEPTH + 1);

    logic signed [ERR_W-1:0] queue_q [D_QUEUE_DEPTH];
    logic signed [ERR_W-1:0] queue_d [D_QUEUE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic signed [PID_W-1:0] pid_d;
    logic signed [31:0]      diff_s, err_full_s, d_full_s, pid_full_s, i_term_s;
    logic signed [ERR_W-1:0] err_s;

`ifdef FLGHT_I_TERM_EN
    localparam int INT_W = ERR_W + 6;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [31:0]      integ_full_s;

    // Integral accumulator: cleared while calibrating, saturating add on vld.
    always_comb begin
        integ_full_s = sat_signed(32'(integ_q) + 32'(err_s), INT_W);
        if (cal) begin
            integ_d = '0;
        end else if (vld) begin
            integ_d = integ_full_s[INT_W-1:0];
        end else begin
            integ_d = integ_q;
        end
        i_term_s = 32'(integ_q) >>> 6;
    end

    // Integral accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q <= '0;
        end else begin
            integ_q <= integ_d;
        end
    end
`else
    // No integral path in this build.
    always_comb begin
        i_term_s = 32'sd0;
    end
`endif

    // Error, D difference (gated until the queue holds a full history), pid and queue update.
    always_comb begin
        diff_s     = 32'(act) - 32'(des);
        err_full_s = sat_signed(diff_s, ERR_W);
        err_s      = err_full_s[ERR_W-1:0];
        if (fill_cnt_q == CNT_W'(D_QUEUE_DEPTH)) begin
            d_full_s = sat_signed(32'(err_s) - 32'(queue_q[wr_ptr_q]), D_DIFF_W);
        end else begin
            d_full_s = 32'sd0;
        end
        pid_full_s = sat_signed(32'(err_s) * P_COEFF + d_full_s * D_COEFF + i_term_s, PID_W);

        queue_d    = queue_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        pid_d      = pid_q;
        if (vld) begin
            queue_d[wr_ptr_q] = err_s;
            pid_d             = pid_full_s[PID_W-1:0];
            if (wr_ptr_q == PTR_W'(D_QUEUE_DEPTH - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            queue_d = queue_q;
        end
        // Calibration forces a fresh warm-up; the pointer keeps moving regardless.
        if (cal) begin
            fill_cnt_d = '0;
        end else if (vld && (fill_cnt_q != CNT_W'(D_QUEUE_DEPTH))) begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end else begin
            fill_cnt_d = fill_cnt_q;
        end
    end

    // Stage-1 state: queue, pointer, fill count and pid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            pid_q      <= '0;
        end else begin
            queue_q    <= queue_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            pid_q      <= pid_d;
        end
    end
endmodule

// File: rtl/flght_cntrl_gen.sv
// -----------------------------------------------------------------------------
// flght_cntrl_gen
// Three-axis PD flight controller with quad-motor mixing.
// Ports: clk, rst (sync active-high), bus (flght_cntrl_gen_if.slave):
//   in : vld, inertial_cal, d_ptch/d_roll/d_yaw, ptch/roll/yaw, thrst
//   out: frnt_spd/bck_spd/lft_spd/rght_spd, out_vld
// Stage 1 (pd_axis x3) registers pid on vld; stage 2 mixes into registered
// motor speeds one cycle later. Macro FLGHT_I_TERM_EN enables the I term.
// -----------------------------------------------------------------------------
module flght_cntrl_gen
    import flght_cntrl_pkg::*;
#(
    parameter int ERR_W         = 10,
    parameter int D_QUEUE_DEPTH = 12,
    parameter int D_DIFF_W      = 7,
    parameter int P_COEFF       = 6,
    parameter int D_COEFF       = 2,
    parameter int PID_W         = 12,
    parameter int THRST_W       = 9,
    parameter int SPD_W         = 11
) (
    input logic               clk,
    input logic               rst,
    flght_cntrl_gen_if.slave  bus
);
    logic signed [PID_W-1:0] pid_s [3];
    logic                    s1_vld_q, s1_vld_d;
    logic [SPD_W-1:0]        frnt_q, frnt_d, bck_q, bck_d, lft_q, lft_d, rght_q, rght_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [31:0]      base_s, p_s, r_s, y_s;
    logic [31:0]             frnt_c, bck_c, lft_c, rght_c;

    pd_axis #(.ERR_W(ERR_W), .D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_DIFF_W(D_DIFF_W),
              .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .PID_W(PID_W)) u_ptch (
        .clk(clk), .rst(rst), .vld(bus.vld), .cal(bus.inertial_cal),
        .act(bus.ptch), .des(bus.d_ptch), .pid_q(pid_s[AX_PTCH]));

    pd_axis #(.ERR_W(ERR_W), .D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_DIFF_W(D_DIFF_W),
              .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .PID_W(PID_W)) u_roll (
        .clk(clk), .rst(rst), .vld(bus.vld), .cal(bus.inertial_cal),
        .act(bus.roll), .des(bus.d_roll), .pid_q(pid_s[AX_ROLL]));

    pd_axis #(.ERR_W(ERR_W), .D_QUEUE_DEPTH(D_QUEUE_DEPTH), .D_DIFF_W(D_DIFF_W),
              .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .PID_W(PID_W)) u_yaw (
        .clk(clk), .rst(rst), .vld(bus.vld), .cal(bus.inertial_cal),
        .act(bus.yaw), .des(bus.d_yaw), .pid_q(pid_s[AX_YAW]));

    // Motor mixing with unsigned clamp; calibration overrides all four speeds.
    always_comb begin
        s1_vld_d  = bus.vld;
        base_s    = $signed(32'(bus.thrst)) + MIN_RUN_SPD;
        p_s       = 32'(pid_s[AX_PTCH]);
        r_s       = 32'(pid_s[AX_ROLL]);
        y_s       = 32'(pid_s[AX_YAW]);
        frnt_c    = clamp_unsigned(base_s - p_s - y_s, SPD_W);
        bck_c     = clamp_unsigned(base_s + p_s - y_s, SPD_W);
        lft_c     = clamp_unsigned(base_s - r_s + y_s, SPD_W);
        rght_c    = clamp_unsigned(base_s + r_s + y_s, SPD_W);
        out_vld_d = s1_vld_q & ~bus.inertial_cal;
        // Speeds only move for a new sample or calibration, so idle cycles
        // (including right after reset) leave the outputs untouched.
        if (bus.inertial_cal) begin
            frnt_d = SPD_W'(CAL_SPEED);
            bck_d  = SPD_W'(CAL_SPEED);
            lft_d  = SPD_W'(CAL_SPEED);
            rght_d = SPD_W'(CAL_SPEED);
        end else if (s1_vld_q) begin
            frnt_d = frnt_c[SPD_W-1:0];
            bck_d  = bck_c[SPD_W-1:0];
            lft_d  = lft_c[SPD_W-1:0];
            rght_d = rght_c[SPD_W-1:0];
        end else begin
            frnt_d = frnt_q;
            bck_d  = bck_q;
            lft_d  = lft_q;
            rght_d = rght_q;
        end
    end

    // Stage-1 valid and stage-2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            frnt_q    <= '0;
            bck_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            frnt_q    <= frnt_d;
            bck_q     <= bck_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.frnt_spd = frnt_q;
    assign bus.bck_spd  = bck_q;
    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.out_vld  = out_vld_q;
endmodule

// File: tb/tb_flght_cntrl_gen.sv
// -----------------------------------------------------------------------------
// tb_flght_cntrl_gen
// Directed-vector bench for flght_cntrl_gen (default build, no I term).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_flght_cntrl_gen;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    flght_cntrl_gen_if #(.THRST_W(9), .SPD_W(11)) bus_if ();

    flght_cntrl_gen dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_spd(input string tag, input int f, input int b, input int l,
                           input int r, input int ov);
        chk({tag, ".frnt"}, int'(bus_if.frnt_spd), f);
        chk({tag, ".bck"},  int'(bus_if.bck_spd),  b);
        chk({tag, ".lft"},  int'(bus_if.lft_spd),  l);
        chk({tag, ".rght"}, int'(bus_if.rght_spd), r);
        chk({tag, ".ovld"}, int'(bus_if.out_vld),  ov);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    // Apply one vld with the given angles; returns after the 2nd rising edge.
    task automatic do_vld(input logic signed [15:0] p, input logic signed [15:0] dp,
                          input logic signed [15:0] r, input logic signed [15:0] y);
        bus_if.ptch   = p;
        bus_if.d_ptch = dp;
        bus_if.roll   = r;
        bus_if.yaw    = y;
        bus_if.vld    = 1'b1;
        @(negedge clk);
        bus_if.vld    = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus_if.vld = 1'b1;
        cycles(2);
        rst        = 1'b0;
        bus_if.vld = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                 = 1'b1;
        bus_if.vld          = 1'b0;
        bus_if.inertial_cal = 1'b0;
        bus_if.d_ptch       = 16'sd0;
        bus_if.d_roll       = 16'sd0;
        bus_if.d_yaw        = 16'sd0;
        bus_if.ptch         = 16'sd0;
        bus_if.roll         = 16'sd0;
        bus_if.yaw          = 16'sd0;
        bus_if.thrst        = 9'd100;
        @(negedge clk);

        // 1: reset wins over vld; idle after reset leaves everything at 0
        do_reset();
        chk_spd("rst", 0, 0, 0, 0, 0);
        cycles(3);
        chk_spd("idle", 0, 0, 0, 0, 0);

        // 2: level hover
        do_vld(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("hover", 516, 516, 516, 516, 1);
        cycles(1);
        chk("hover.pulse", int'(bus_if.out_vld), 0);

        // 3: pitch error 10, D gated
        do_vld(16'sd10, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("ptch10", 456, 576, 516, 516, 1);

        // 4: extreme pitch error saturates error, pid and speeds
        do_vld(16'sh7FFF, 16'sh8000, 16'sd0, 16'sd0);
        chk_spd("ptchsat", 0, 2047, 516, 516, 1);

        // roll -5 (pid -30) and yaw 3 (pid 18)
        do_vld(16'sd0, 16'sd0, -16'sd5, 16'sd3);
        chk_spd("rollyaw", 498, 498, 564, 504, 1);

        // 5: warm-up and D term
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            do_vld(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        end
        do_vld(16'sd8, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("warm5", 468, 564, 516, 516, 1);
        for (int k = 6; k <= 12; k++) begin
            do_vld(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        end
        do_vld(16'sd8, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("dterm", 452, 580, 516, 516, 1);

        // 6: calibration overrides speeds and suppresses out_vld
        bus_if.inertial_cal = 1'b1;
        cycles(1);
        chk_spd("cal", 290, 290, 290, 290, 0);
        do_vld(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("calvld", 290, 290, 290, 290, 0);
        bus_if.inertial_cal = 1'b0;
        cycles(1);

        // D re-warms: twelve samples with no D contribution
        for (int k = 1; k <= 12; k++) begin
            do_vld(16'sd8, 16'sd0, 16'sd0, 16'sd0);
            chk($sformatf("rewarm%0d.frnt", k), int'(bus_if.frnt_spd), 468);
        end
        // first sample with D active: diff 0-8 -> pid -16
        do_vld(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        chk_spd("postcal", 532, 500, 516, 516, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
